mc_datapath_v2: RTL and testbench

//  Next-generation multicycle ARM-subset datapath: PC, IR, data, A/WriteData and ALUOut regs,
//  16-entry regfile, extender, ALU and operand/result muxes, driven by the multicycle controller.

---
 rtl/mc_datapath_v2.sv | 92 +++++++++
 tb/tb_mc_datapath_v2.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_v2.sv
// mc_datapath_v2: multicycle ARM-subset datapath with MemReady-stalled fetch/load capture and retired-instruction count.
// Define SHIFT_EN to route the operand-B register value through the LSL/LSR/ASR/ROR immediate shifter.
module mc_datapath_v2 #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] PC_STEP = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  input  logic             MemReady,
  output logic [31:0]      Instr,
  output logic [3:0]       ALUFlags,
  output logic [WIDTH-1:0] InstRet,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [1:0]       ALUControl
);
  logic [WIDTH-1:0] pc, data, a, aluout, rd1, rd2, srca, srcb, shb, ext_imm, alu_res, result;
  logic [WIDTH-1:0] rf [15];
  logic [WIDTH:0] sum;
  logic [3:0] ra1, ra2, wa;
  logic c, v;
  assign wa  = Instr[15:12];
  assign ra1 = RegSrc[0] ? 4'd15 : Instr[19:16];
  assign ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  // R15 is not stored: reads see the current Result (PC+8 path)
  assign rd1 = (ra1 == 4'd15) ? result : rf[ra1];
  assign rd2 = (ra2 == 4'd15) ? result : rf[ra2];
  always_comb
    ext_imm = (ImmSrc == 2'b00) ? WIDTH'(Instr[7:0]) :
              (ImmSrc == 2'b01) ? WIDTH'(Instr[11:0]) :
              (ImmSrc == 2'b10) ? WIDTH'($signed({Instr[23:0], 2'b00})) : '0;
`ifdef SHIFT_EN
  logic [4:0] shamt;
  logic signed [WIDTH-1:0] asr;
  assign shamt = Instr[11:7];
  assign asr = $signed(WriteData) >>> shamt;
  always_comb
    shb = (shamt == 5'd0)       ? WriteData :
          (Instr[6:5] == 2'b00) ? WriteData << shamt :
          (Instr[6:5] == 2'b01) ? WriteData >> shamt :
          (Instr[6:5] == 2'b10) ? asr :
          (WriteData >> shamt) | (WriteData << (WIDTH - int'(shamt)));
`else
  assign shb = WriteData;
`endif
  always_comb begin
    srca = (ALUSrcA == 2'b01) ? pc : (ALUSrcA == 2'b10) ? aluout : a;
    srcb = (ALUSrcB == 2'b10) ? PC_STEP : ALUSrcB[0] ? ext_imm : shb;
    sum = ALUControl[0] ? {1'b0, srca} + {1'b0, ~srcb} + (WIDTH+1)'(1) : {1'b0, srca} + {1'b0, srcb};
    alu_res = ALUControl[1] ? (ALUControl[0] ? srca | srcb : srca & srcb) : sum[WIDTH-1:0];
    c = ~ALUControl[1] & sum[WIDTH];
    v = ~ALUControl[1] & (srca[WIDTH-1] ^ sum[WIDTH-1]) & ~(srca[WIDTH-1] ^ srcb[WIDTH-1] ^ ALUControl[0]);
    ALUFlags = {alu_res[WIDTH-1], alu_res == '0, c, v};
    result = (ResultSrc == 2'b01) ? data : (ResultSrc == 2'b10) ? alu_res : aluout;
    Adr = AdrSrc ? result : pc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= PC_RESET;
      Instr <= '0;
      data <= '0;
      a <= '0;
      WriteData <= '0;
      aluout <= '0;
      InstRet <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite && MemReady) begin
        Instr <= ReadData[31:0];
        InstRet <= InstRet + WIDTH'(1);
      end
      if (MemReady) data <= ReadData;
      a <= rd1;
      WriteData <= rd2;
      aluout <= alu_res;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else if (RegWrite && wa != 4'd15) rf[wa] <= result;
endmodule

// File: tb/tb_mc_datapath_v2.sv
// tb_mc_datapath_v2: table-driven ALU vectors, directed multicycle sequences and random cycles against a reference model.
module tb_mc_datapath_v2;
  logic clk = 1'b0;
  logic reset, MemReady, PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [31:0] ReadData, Adr, WriteData, Instr, InstRet;
  logic [3:0] ALUFlags;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  int passed = 0, total = 0;
  logic [31:0] m_pc, m_ir, m_data, m_a, m_wd, m_aluout, m_ret;
  logic [31:0] m_rf [16];

  typedef struct {logic [1:0] op; logic [31:0] a, b, res; logic [3:0] fl;} vec_t;
  vec_t vt [9];
  logic [31:0] shexp [4];

  mc_datapath_v2 dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .Instr(Instr), .ALUFlags(ALUFlags), .InstRet(InstRet),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [35:0] alu_m(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    longint s, sv;
    logic [31:0] r;
    logic cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (op)
      2'd0: begin
        s = longint'({32'b0, x}) + longint'({32'b0, y});
        r = s[31:0];
        cf = s[32];
        sv = longint'($signed(x)) + longint'($signed(y));
        vf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      2'd1: begin
        r = x - y;
        cf = x >= y;
        sv = longint'($signed(x)) - longint'($signed(y));
        vf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      2'd2: r = x & y;
      default: r = x | y;
    endcase
    return {r[31], r == 32'd0, cf, vf, r};
  endfunction

  function automatic logic [31:0] shf(input logic [31:0] w, input logic [4:0] sh, input logic [1:0] t);
    logic signed [31:0] sw;
    logic [63:0] dbl;
    sw = w;
    dbl = {w, w} >> sh;
    if (sh == 5'd0) return w;
    case (t)
      2'd0: return w << sh;
      2'd1: return w >> sh;
      2'd2: return sw >>> sh;
      default: return dbl[31:0];
    endcase
  endfunction

  task automatic m_reset();
    m_pc = 0; m_ir = 0; m_data = 0; m_a = 0; m_wd = 0; m_aluout = 0; m_ret = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
  endtask

  task automatic tick();
    logic [31:0] ext, sa, sb, alu, res, r1, r2;
    logic [3:0] fl, ra1, ra2;
    #1;
    ext = (ImmSrc == 0) ? {24'b0, m_ir[7:0]} : (ImmSrc == 1) ? {20'b0, m_ir[11:0]} :
          (ImmSrc == 2) ? {{6{m_ir[23]}}, m_ir[23:0], 2'b00} : 32'd0;
    sa = (ALUSrcA == 1) ? m_pc : (ALUSrcA == 2) ? m_aluout : m_a;
`ifdef SHIFT_EN
    sb = (ALUSrcB == 2) ? 32'd4 : ALUSrcB[0] ? ext : shf(m_wd, m_ir[11:7], m_ir[6:5]);
`else
    sb = (ALUSrcB == 2) ? 32'd4 : ALUSrcB[0] ? ext : m_wd;
`endif
    {fl, alu} = alu_m(sa, sb, ALUControl);
    res = (ResultSrc == 1) ? m_data : (ResultSrc == 2) ? alu : m_aluout;
    ra1 = RegSrc[0] ? 4'd15 : m_ir[19:16];
    ra2 = RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
    r1 = (ra1 == 15) ? res : m_rf[ra1];
    r2 = (ra2 == 15) ? res : m_rf[ra2];
    chk("adr", Adr, AdrSrc ? res : m_pc);
    chk("flags", {28'b0, ALUFlags}, {28'b0, fl});
    chk("instr", Instr, m_ir);
    chk("instret", InstRet, m_ret);
    chk("wdata", WriteData, m_wd);
    @(posedge clk);
    if (RegWrite && m_ir[15:12] != 4'd15) m_rf[m_ir[15:12]] = res;
    if (PCWrite) m_pc = res;
    if (IRWrite && MemReady) begin
      m_ir = ReadData;
      m_ret = m_ret + 1;
    end
    if (MemReady) m_data = ReadData;
    m_a = r1;
    m_wd = r2;
    m_aluout = alu;
    @(negedge clk);
  endtask

  task automatic idle();
    {PCWrite, RegWrite, IRWrite, AdrSrc, MemReady} = '0;
    {RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl} = '0;
    ReadData = '0;
  endtask

  task automatic fetch(input logic [31:0] w);
    idle(); IRWrite = 1; MemReady = 1; ReadData = w; tick();
  endtask

  task automatic set_pc(input logic [31:0] val);
    idle(); ReadData = val; MemReady = 1; tick();
    idle(); ResultSrc = 1; PCWrite = 1; tick();
  endtask

  task automatic load_reg(input logic [3:0] r, input logic [31:0] val);
    fetch(32'hE000_0002 | (32'(r) << 12));
    idle(); ReadData = val; MemReady = 1; tick();
    idle(); ResultSrc = 1; RegWrite = 1; tick();
  endtask

  initial begin
    vt[0] = '{2'd1, 32'h5, 32'h5, 32'h0, 4'b0110};
    vt[1] = '{2'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001};
    vt[2] = '{2'd3, 32'h0, 32'h0, 32'h0, 4'b0100};
    vt[3] = '{2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110};
    vt[4] = '{2'd1, 32'h3, 32'h5, 32'hFFFFFFFE, 4'b1000};
    vt[5] = '{2'd1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011};
    vt[6] = '{2'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000};
    vt[7] = '{2'd3, 32'h0F, 32'hF0, 32'hFF, 4'b0000};
    vt[8] = '{2'd0, 32'h80000000, 32'h80000000, 32'h0, 4'b0111};
`ifdef SHIFT_EN
    shexp = '{32'h00000002, 32'h40000000, 32'hC0000000, 32'hC0000000};
`else
    shexp = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001};
`endif
    reset = 1; idle(); m_reset();
    repeat (2) @(negedge clk);
    chk("rst_adr", Adr, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_instret", InstRet, 32'h0);
    chk("rst_wdata", WriteData, 32'h0);
    chk("rst_flags", {28'b0, ALUFlags}, 32'b0100);
    reset = 0;
    // reset mid-run
    repeat (7) fetch($urandom);
    set_pc(32'h40);
    idle(); #1;
    chk("pre_pc", Adr, 32'h40);
    chk("pre_instret", InstRet, 32'd7);
    #1 reset = 1;
    #1;
    chk("async_pc", Adr, 32'h0);
    chk("async_instret", InstRet, 32'h0);
    m_reset();
    @(negedge clk) reset = 0;
    // stalled fetch
    idle(); IRWrite = 1; ReadData = 32'hE2811005;
    repeat (3) tick();
    chk("stall_instr", Instr, 32'h0);
    chk("stall_instret", InstRet, 32'h0);
    MemReady = 1; tick();
    chk("fetch_instr", Instr, 32'hE2811005);
    chk("fetch_instret", InstRet, 32'd1);
    // ADD immediate into R1
    load_reg(1, 32'd3);
    fetch(32'hE2811005);
    idle(); tick();
    ALUSrcB = 1; ResultSrc = 2; AdrSrc = 1; #1;
    chk("addimm_res", Adr, 32'd8);
    tick();
    idle(); AdrSrc = 1; RegWrite = 1; #1;
    chk("addimm_aluout", Adr, 32'd8);
    tick();
    idle(); RegSrc = 2; tick();
    #1 chk("addimm_r1", WriteData, 32'd8);
    // ALU vectors
    for (int i = 0; i < 9; i++) begin
      load_reg(2, vt[i].b);
      set_pc(vt[i].a);
      idle(); ALUSrcA = 1; ALUControl = vt[i].op; ResultSrc = 2; AdrSrc = 1; #1;
      chk($sformatf("vec%0d_res", i), Adr, vt[i].res);
      chk($sformatf("vec%0d_flags", i), {28'b0, ALUFlags}, {28'b0, vt[i].fl});
      tick();
    end
    // R15 read and ignored R15 write
    fetch(32'hE000F002);
    set_pc(32'h100);
    idle(); RegSrc = 3; ResultSrc = 2; ALUSrcA = 1; ALUSrcB = 2; AdrSrc = 1; RegWrite = 1; #1;
    chk("r15_result", Adr, 32'h104);
    tick();
    idle(); ALUSrcB = 1; ImmSrc = 3; ResultSrc = 2; AdrSrc = 1; #1;
    chk("r15_rd1", Adr, 32'h104);
    chk("r15_rd2", WriteData, 32'h104);
    AdrSrc = 0; #1;
    chk("r15_pc", Adr, 32'h100);
    tick();
    // operand-B shifter
    load_reg(2, 32'h80000001);
    set_pc(32'h0);
    for (int t = 0; t < 4; t++) begin
      fetch(32'hE0000002 | (32'd1 << 7) | (32'(t) << 5));
      idle(); tick();
      ALUSrcA = 1; ResultSrc = 2; AdrSrc = 1; #1;
      chk($sformatf("shift%0d", t), Adr, shexp[t]);
      tick();
    end
    // random cycles
    for (int n = 0; n < 400; n++) begin
      {PCWrite, RegWrite, IRWrite, AdrSrc, MemReady} = 5'($urandom);
      {RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl} = 12'($urandom);
      ReadData = $urandom;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
